// File: rtl/or_req_arbiter.sv
// Round-robin arbiter: one registered one-hot grant among N requesters, held until done or request drop.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module or_req_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic                 any_req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);
  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] last_q, last_d;
  logic           rel_norm;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
  logic          rel_force;
`endif

  // First requester after the last-served one, wrapping modulo N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] l);
    logic found;
    int   idx;
    pick  = l;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(l) + k) % N;
      if (!found && r[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  assign any_req = |req;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    rel_norm = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
    rel_force = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_id_d = pick(req, last_q);
          gnt_d    = {{(N-1){1'b0}}, 1'b1} << gnt_id_d;
          state_d  = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d   = '0;
`endif
        end
      end
      GRANT: begin
        rel_norm = done || !req[gnt_id_q];
`ifdef ARB_TIMEOUT_EN
        // hold_q counts completed grant cycles minus one; this edge ends cycle MAX_HOLD.
        rel_force = !rel_norm && (hold_q == HW'(MAX_HOLD - 1));
        if (rel_norm || rel_force) begin
          gnt_d     = '0;
          last_d    = gnt_id_q;
          state_d   = IDLE;
          timeout_d = rel_force;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`else
        if (rel_norm) begin
          gnt_d   = '0;
          last_d  = gnt_id_q;
          state_d = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= IDW'(N - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == GRANT);
endmodule

// File: tb/tb_or_req_arbiter.sv
// Bench for or_req_arbiter: directed stimulus, per-cycle comparison against a behavioural
// round-robin model, plus literal expectations for the key scenarios.
module tb_or_req_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic         any_req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  or_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .any_req(any_req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model state: owner index (-1 when idle), last served, cycles the grant has been seen.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_gid   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int o, l, g, h, idx;
    bit t;
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= N - 1;
      m_gid   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      o = m_owner; l = m_last; g = m_gid; h = m_held; t = 1'b0;
      if (o < 0) begin
        for (int k = 1; k <= N; k++) begin
          idx = (l + k) % N;
          if (o < 0 && req[idx]) begin
            o = idx; g = idx; h = 0;
          end
        end
      end else if (done || !req[o]) begin
        l = o; o = -1;
      end else begin
        h = h + 1;
`ifdef ARB_TIMEOUT_EN
        if (h >= MAX_HOLD) begin
          l = o; o = -1; t = 1'b1;
        end
`endif
      end
      m_owner <= o;
      m_last  <= l;
      m_gid   <= g;
      m_held  <= h;
      m_to    <= t;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (chk_on) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      vectors++;
      if (gnt !== eg || gnt_id !== 2'(m_gid) || busy !== (m_owner >= 0) ||
          timeout !== m_to || any_req !== (|req) || !$onehot0(gnt)) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t gnt=%b/%b gnt_id=%0d/%0d busy=%b/%b timeout=%b/%b any_req=%b/%b (actual/required)",
                 $time, gnt, eg, gnt_id, m_gid, busy, (m_owner >= 0), timeout, m_to, any_req, |req);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] fair_exp [5];
  int cnt;

  initial begin
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
    rst_n = 1'b0; req = '0; done = 1'b0;
    #1;
    chk_on = 1'b1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_gnt_id", 32'(gnt_id), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single requester; done while idle has no effect.
    done = 1'b1;
    step(1);
    done = 1'b0;
    req = 4'b0100;
    #1;
    chk("any_req_high", 32'(any_req), 32'h1);
    step(1);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_gnt_id", 32'(gnt_id), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    done = 1'b1;
    step(1);
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_busy", 32'(busy), 32'h0);
    chk("idle_gnt_id_hold", 32'(gnt_id), 32'h2);
    done = 1'b0;
    req = '0;
    #1;
    chk("any_req_low", 32'(any_req), 32'h0);

    // Async reset mid-grant restores requester 0 priority.
    req = 4'b0010;
    step(1);
    chk("rst_pre_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    step(1);
    rst_n = 1'b1;
    req = 4'b0011;
    step(1);
    chk("rst_prio0", 32'(gnt), 32'h1);
    req = '0;
    step(2);

    // Fairness with all requesters held.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("fair_gnt", 32'(gnt), 32'(fair_exp[k]));
      done = 1'b1;
      step(1);
      chk("fair_idle", 32'(gnt), 32'h0);
      done = 1'b0;
    end
    req = '0;
    step(1);

    // Rotation skip from last=1.
    req = 4'b0010;
    step(1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    req = 4'b1010;
    step(1);
    chk("skip_gnt3", 32'(gnt), 32'h8);
    chk("skip_id3", 32'(gnt_id), 32'h3);
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(1);
    chk("skip_gnt1", 32'(gnt), 32'h2);
    done = 1'b1;
    step(1);
    done = 1'b0;
    req = '0;
    step(1);

    // Owner drops request without done; last becomes 2.
    req = 4'b0100;
    step(1);
    chk("drop_gnt", 32'(gnt), 32'h4);
    req = 4'b0101;
    step(2);
    chk("drop_held", 32'(gnt), 32'h4);
    req = 4'b0001;
    step(1);
    chk("drop_rel", 32'(gnt), 32'h0);
    req = 4'b0101;
    step(1);
    chk("drop_last2", 32'(gnt), 32'h1);
    req = 4'b0111;
    step(1);
    chk("nonowner_ignored", 32'(gnt), 32'h1);
    req = '0;
    step(2);

    // Long hold on requester 0.
    req = 4'b0001;
    step(1);
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (gnt == 4'b0001 && cnt < 40) begin
      cnt++;
      step(1);
    end
    chk("timeout_len", 32'(cnt), 32'(MAX_HOLD));
    chk("timeout_pulse", 32'(timeout), 32'h1);
    step(1);
    chk("timeout_clear", 32'(timeout), 32'h0);
`else
    cnt = 0;
    step(100);
    chk("hold_gnt", 32'(gnt), 32'h1);
    chk("hold_timeout", 32'(timeout), 32'h0);
`endif
    req = '0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
